// File: rtl/probe_capture.sv
// probe_capture: edge-triggered capture of a single-bit probe into a word buffer, drained over valid/ready.
// Ports:
//   clk, rst_n   clock and synchronous active-low reset
//   probe_in     registered probe sample, one per cycle
//   arm          start request, honoured only in IDLE
//   abort        return to IDLE from any state
//   trig_mode    00 immediate, 01 rising, 10 falling, 11 any edge
//   state_o      0 IDLE, 1 ARMED, 2 CAPTURE, 3 READOUT
//   done         high throughout READOUT
//   m_data/m_valid/m_ready  readout stream of captured words
module probe_capture #(
   parameter int WORD_W = 32,
   parameter int DEPTH  = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              probe_in,
   input  logic              arm,
   input  logic              abort,
   input  logic [1:0]        trig_mode,
   output logic [1:0]        state_o,
   output logic              done,
   output logic [WORD_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready
);
   localparam int BW = $clog2(WORD_W);
   localparam int AW = $clog2(DEPTH);
   localparam logic [BW-1:0] BIT_LAST  = BW'(WORD_W - 1);
   localparam logic [AW-1:0] WORD_LAST = AW'(DEPTH - 1);
   typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, CAPTURE = 2'd2, READOUT = 2'd3} state_t;
   state_t            r_state;
   logic              r_prev;
   logic              r_done;
   logic              r_valid;
   logic [BW-1:0]     r_bit_cnt;
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [WORD_W-1:0] r_shift;
   logic [WORD_W-1:0] r_buf [DEPTH];
   logic [WORD_W-1:0] w_word;
   logic              w_trig;
   logic              w_xfer;
   logic              w_we;
   // LSB-first packing: the newest sample enters at the top, so after WORD_W shifts sample 0 sits in bit 0
   assign w_word = {probe_in, r_shift[WORD_W-1:1]};
   // bit 0 of the mode enables rising, bit 1 enables falling; both together give any edge
   assign w_trig = (trig_mode == 2'b00) | (trig_mode[0] & !r_prev & probe_in) | (trig_mode[1] & r_prev & !probe_in);
   assign w_xfer = r_valid & m_ready;
   assign w_we   = rst_n & !abort & (r_state == CAPTURE) & (r_bit_cnt == BIT_LAST);
   assign state_o = r_state;
   assign done    = r_done;
   assign m_valid = r_valid;
   assign m_data  = r_buf[r_rd_ptr];
   always_ff @(posedge clk) begin
      if (w_we) r_buf[r_wr_ptr] <= w_word;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_prev    <= 1'b0;
         r_done    <= 1'b0;
         r_valid   <= 1'b0;
         r_bit_cnt <= '0;
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_shift   <= '0;
      end else begin
         r_prev <= probe_in;
         if (abort) begin
            r_state   <= IDLE;
            r_done    <= 1'b0;
            r_valid   <= 1'b0;
            r_bit_cnt <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
         end else begin
            case (r_state)
               IDLE: if (arm) begin
                  r_state   <= ARMED;
                  r_bit_cnt <= '0;
                  r_wr_ptr  <= '0;
                  r_rd_ptr  <= '0;
               end
               ARMED: if (w_trig) begin
                  r_state   <= CAPTURE;
                  r_shift   <= w_word;
                  r_bit_cnt <= BW'(1);
               end
               CAPTURE: begin
                  r_shift <= w_word;
                  if (r_bit_cnt == BIT_LAST) begin
                     r_bit_cnt <= '0;
                     r_wr_ptr  <= r_wr_ptr + 1'b1;
                     if (r_wr_ptr == WORD_LAST) begin
                        r_state <= READOUT;
                        r_done  <= 1'b1;
                        r_valid <= 1'b1;
                     end
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 1'b1;
                  end
               end
               READOUT: if (w_xfer) begin
                  r_rd_ptr <= r_rd_ptr + 1'b1;
                  if (r_rd_ptr == WORD_LAST) begin
                     r_state <= IDLE;
                     r_done  <= 1'b0;
                     r_valid <= 1'b0;
                  end
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_probe_capture.sv
// tb_probe_capture: directed checks of probe_capture with WORD_W=8, DEPTH=4.
module tb_probe_capture;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       probe_in = 1'b0;
   logic       arm = 1'b0;
   logic       abort = 1'b0;
   logic [1:0] trig_mode = 2'b00;
   logic [1:0] state_o;
   logic       done;
   logic [7:0] m_data;
   logic       m_valid;
   logic       m_ready = 1'b0;
   int         n_checks = 0;
   int         n_errors = 0;
   logic [7:0] exp_w [4];
   probe_capture #(.WORD_W(8), .DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .probe_in(probe_in), .arm(arm), .abort(abort),
      .trig_mode(trig_mode), .state_o(state_o), .done(done), .m_data(m_data),
      .m_valid(m_valid), .m_ready(m_ready)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic tick(input logic p);
      probe_in = p;
      @(posedge clk);
      #1;
   endtask
   task automatic do_arm(input logic [1:0] mode, input logic p);
      trig_mode = mode;
      arm = 1'b1;
      tick(p);
      arm = 1'b0;
      chk("armed", 32'(state_o), 32'd1);
   endtask
   task automatic capture(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2, input logic [7:0] w3);
      exp_w[0] = w0;
      exp_w[1] = w1;
      exp_w[2] = w2;
      exp_w[3] = w3;
      for (int k = 0; k < 32; k++) begin
         tick(exp_w[k / 8][k % 8]);
         if (k == 0) chk("cap_start", 32'(state_o), 32'd2);
         if (k == 30) chk("cap_hold", 32'(state_o), 32'd2);
      end
      probe_in = 1'b0;
      chk("readout", 32'(state_o), 32'd3);
      chk("done_hi", 32'(done), 32'd1);
      chk("valid_hi", 32'(m_valid), 32'd1);
   endtask
   task automatic drain(input logic toggle);
      for (int i = 0; i < 4; i++) begin
         if (toggle) begin
            m_ready = 1'b0;
            tick(1'b0);
            chk("stall_data", 32'(m_data), 32'(exp_w[i]));
            chk("stall_valid", 32'(m_valid), 32'd1);
         end
         chk("word", 32'(m_data), 32'(exp_w[i]));
         m_ready = 1'b1;
         tick(1'b0);
         m_ready = 1'b0;
      end
      chk("end_state", 32'(state_o), 32'd0);
      chk("end_valid", 32'(m_valid), 32'd0);
      chk("end_done", 32'(done), 32'd0);
   endtask
   initial begin
      tick(1'b0);
      tick(1'b1);
      rst_n = 1'b1;
      chk("rst_state", 32'(state_o), 32'd0);
      chk("rst_valid", 32'(m_valid), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      for (int i = 0; i < 6; i++) tick(1'(i));
      chk("idle_stay", 32'(state_o), 32'd0);
      arm = 1'b1;
      abort = 1'b1;
      tick(1'b0);
      arm = 1'b0;
      abort = 1'b0;
      chk("abort_wins", 32'(state_o), 32'd0);
      do_arm(2'b01, 1'b0);
      for (int i = 0; i < 5; i++) tick(1'b0);
      chk("wait_rise", 32'(state_o), 32'd1);
      capture(8'h4B, 8'h4B, 8'h4B, 8'h4B);
      drain(1'b0);
      do_arm(2'b01, 1'b0);
      for (int i = 0; i < 5; i++) tick(1'b0);
      capture(8'h4B, 8'h4B, 8'h4B, 8'h4B);
      drain(1'b1);
      do_arm(2'b10, 1'b1);
      for (int i = 0; i < 20; i++) tick(1'b1);
      chk("wait_fall", 32'(state_o), 32'd1);
      capture(8'hFE, 8'hFF, 8'hFF, 8'hFF);
      chk("fall_bit0", 32'(m_data[0]), 32'd0);
      drain(1'b0);
      do_arm(2'b00, 1'b1);
      capture(8'hFF, 8'hFF, 8'hFF, 8'hFF);
      drain(1'b0);
      do_arm(2'b01, 1'b0);
      for (int k = 0; k < 13; k++) tick(1'b1);
      chk("pre_abort", 32'(state_o), 32'd2);
      abort = 1'b1;
      tick(1'b1);
      abort = 1'b0;
      chk("abort_state", 32'(state_o), 32'd0);
      chk("abort_valid", 32'(m_valid), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      do_arm(2'b11, 1'b0);
      tick(1'b0);
      chk("wait_any", 32'(state_o), 32'd1);
      capture(8'h11, 8'hA5, 8'h3C, 8'h80);
      drain(1'b0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
